ntt_addr_gen: RTL and testbench
===============================

NTT_ADDR_GEN -- requirements
Module: ntt_addr_gen

Interface
REQ-001 SHALL have parameter LOG_N, default 8: log2 of the ring size N (N = 2^LOG_N); legal range 2..16.
REQ-002 SHALL have parameter WR_DELAY, default 11: butterfly latency in cycles from the read beat to the write beat; legal range 1..32.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: request one full transform; sampled only while idle.
REQ-006 SHALL have port mode, input, 1: 0 = forward (pivot descends LOG_N-1..0), 1 = inverse (pivot ascends 0..LOG_N-1); latched when start is accepted.
REQ-007 SHALL have port stall, input, 1: freezes all sequencing and the delay line while high.
REQ-008 SHALL have port rd_addr_a, output, LOG_N: lower butterfly read address.
REQ-009 SHALL have port rd_addr_b, output, LOG_N: upper butterfly read address.
REQ-010 SHALL have port rd_valid, output, 1: read pair valid.
REQ-011 SHALL have port tw_idx, output, LOG_N-1: twiddle ROM index for the current read beat.
REQ-012 SHALL have port stage, output, clog2(LOG_N): stage count 0..LOG_N-1 of the current read beat.
REQ-013 SHALL have port last_stage, output, 1: high while stage == LOG_N-1 and rd_valid.
REQ-014 SHALL have port wr_addr_a, output, LOG_N: delayed lower write address.
REQ-015 SHALL have port wr_addr_b, output, LOG_N: delayed upper write address.
REQ-016 SHALL have port wr_valid, output, 1: write pair valid.
REQ-017 SHALL have port busy, output, 1: transform in progress.
REQ-018 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-019 SHALL, when idle, accept start=1 at edge T and assert busy, rd_valid at T+1 with stage 0, butterfly j=0.
REQ-020 SHALL ignore start while busy; a start in the same cycle as done SHALL be ignored.
REQ-021 SHALL emit one butterfly per non-stalled cycle, j = 0..N/2-1 per stage, LOG_N stages, for N/2*LOG_N beats total.
REQ-022 SHALL compute pivot p = LOG_N-1-stage (mode 0) or p = stage (mode 1).
REQ-023 SHALL form rd_addr_a by inserting a 0 at bit p of j: ((j >> p) << (p+1)) | (j & (2^p - 1)).
REQ-024 SHALL form rd_addr_b = rd_addr_a | 2^p.
REQ-025 SHALL form tw_idx = (j & (2^p - 1)) << (LOG_N-1-p), truncated to LOG_N-1 bits.
REQ-026 SHALL, after j = N/2-1, wrap j to 0 and increment stage; after the final beat, deassert rd_valid on the next non-stalled cycle.
REQ-027 SHALL, while stall=1, hold j, stage, every read output and every delay-line entry.
REQ-028 SHALL push {rd_valid, rd_addr_a, rd_addr_b} into a WR_DELAY-deep delay line, so that, with no stalls, wr_* equal the read values WR_DELAY cycles later.
REQ-029 SHALL pulse done in the same cycle as wr_valid for the final butterfly; with stall=0 this is cycle T+N/2*LOG_N+WR_DELAY.
REQ-030 SHALL deassert busy in the cycle after done; start is accepted again from that cycle onward.
REQ-031 SHALL keep tw_idx, stage and read addresses at 0 whenever rd_valid=0.

Reset
REQ-032 SHALL, with rst=0 at a clock edge, clear all outputs to 0, clear every delay-line entry (valid and addresses) to 0, and return to idle.
REQ-033 SHALL abort a transform in progress on reset mid-operation, with no done pulse, and accept start on the first edge with rst=1.

Verification
REQ-034 SHALL check LOG_N=3, WR_DELAY=2, mode=0, start at T0 -> read (a,b,tw) pairs are (0,4,0)(1,5,1)(2,6,2)(3,7,3) | (0,2,0)(1,3,2)(4,6,0)(5,7,2) | (0,1,0)(2,3,0)(4,5,0)(6,7,0), with rd_valid in T0+1..T0+12.
REQ-035 SHALL check the same setup with mode=1 -> stage order p=0,1,2: (0,1)x4 pairs, then (0,2)(1,3)(4,6)(5,7), then (0,4)(1,5)(2,6)(3,7); last_stage is high on the final 4 beats only.
REQ-036 SHALL check timing for the REQ-034 setup -> wr_valid in T0+3..T0+14, done only at T0+14, busy in T0+1..T0+14, and start at T0+5 ignored.
REQ-037 SHALL check stall=1 for 3 cycles during beat 6 -> all outputs frozen, and done slips exactly 3 cycles to T0+17.
REQ-038 SHALL check rst=0 at T0+7 -> all outputs 0 next cycle, no done pulse; a new start afterwards runs a clean 12-beat transform.
REQ-039 SHALL check default parameters (LOG_N=8, WR_DELAY=11) -> 1024 beats, each address written exactly twice per stage pair coverage (each of 256 addresses appears once per stage), and done at T0+1035.

Source files
------------

// File: rtl/ntt_addr_gen.sv
// ----------------------------------------------------------------------------
// ntt_addr_gen
// Address sequencer for an in-place radix-2 NTT. For every butterfly beat it
// issues the read address pair and twiddle index, then replays the same
// address pair as a write pair after a fixed butterfly latency.
//
// Parameters
//   LOG_N     log2 of the ring size N (2..16)
//   WR_DELAY  butterfly latency, read beat to write beat (1..32)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-low reset
//   start       request one transform (sampled only while idle)
//   mode        0 = forward (pivot descends), 1 = inverse (pivot ascends)
//   stall       freezes sequencing and the write delay line
//   rd_addr_a   lower read address       rd_addr_b  upper read address
//   rd_valid    read pair valid          tw_idx     twiddle ROM index
//   stage       stage of current beat    last_stage final stage flag
//   wr_addr_a   lower write address      wr_addr_b  upper write address
//   wr_valid    write pair valid
//   busy        transform in progress    done       one-cycle completion pulse
// ----------------------------------------------------------------------------
module ntt_addr_gen #(
   parameter int LOG_N    = 8,
   parameter int WR_DELAY = 11
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     mode,
   input  logic                     stall,
   output logic [LOG_N-1:0]         rd_addr_a,
   output logic [LOG_N-1:0]         rd_addr_b,
   output logic                     rd_valid,
   output logic [LOG_N-2:0]         tw_idx,
   output logic [$clog2(LOG_N)-1:0] stage,
   output logic                     last_stage,
   output logic [LOG_N-1:0]         wr_addr_a,
   output logic [LOG_N-1:0]         wr_addr_b,
   output logic                     wr_valid,
   output logic                     busy,
   output logic                     done
);

   localparam int SW = $clog2(LOG_N);
   // delay-line entry: {valid, final_beat, addr_a, addr_b}
   localparam int DW = 2 * LOG_N + 2;
   localparam logic [LOG_N-2:0] J_MAX     = {(LOG_N-1){1'b1}};
   localparam logic [LOG_N-2:0] J_ONE     = (LOG_N-1)'(1'b1);
   localparam logic [SW-1:0]    S_MAX     = SW'(LOG_N - 1);
   localparam logic [SW-1:0]    STAGE_ONE = SW'(1'b1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t           state_r, state_nxt_s;
   logic [LOG_N-2:0] j_r, j_nxt_s;
   logic [SW-1:0]    stage_r, stage_nxt_s;
   logic             mode_r, mode_nxt_s;

   logic             rd_valid_nxt_s;
   logic [SW-1:0]    pivot_nxt_s;
   logic [LOG_N-1:0] addr_a_nxt_s, addr_b_nxt_s;
   logic [LOG_N-2:0] tw_nxt_s;
   logic             final_beat_s;
   logic             wr_final_s;

   logic [LOG_N-1:0] rd_addr_a_r, rd_addr_b_r;
   logic             rd_valid_r;
   logic [LOG_N-2:0] tw_idx_r;
   logic             last_stage_r;
   logic             busy_r;
   logic             done_r;

   logic [DW-1:0]    dl_r    [WR_DELAY];
   logic [DW-1:0]    dl_in_s [WR_DELAY];

   // Lower address: open a zero at bit p of the butterfly counter j.
   function automatic logic [LOG_N-1:0] lo_addr(input logic [LOG_N-2:0] j,
                                                input logic [SW-1:0]    p);
      logic [LOG_N-1:0] jx;
      logic [LOG_N-1:0] mask;
      jx   = {1'b0, j};
      mask = (LOG_N'(1'b1) << p) - LOG_N'(1'b1);
      return (((jx >> p) << 1'b1) << p) | (jx & mask);
   endfunction

   // Twiddle index: low p bits of j scaled up to the full ROM range.
   // When p = LOG_N-1 the shifted one falls off the top, so the mask wraps
   // to all ones, which is exactly the intended full mask.
   function automatic logic [LOG_N-2:0] tw_of(input logic [LOG_N-2:0] j,
                                              input logic [SW-1:0]    p);
      logic [LOG_N-2:0] mask;
      logic [SW-1:0]    sh;
      mask = ((LOG_N-1)'(1'b1) << p) - (LOG_N-1)'(1'b1);
      sh   = S_MAX - p;
      return (j & mask) << sh;
   endfunction

   // Sequencer next-state: beat counter j, stage counter and phase.
   always_comb begin
      state_nxt_s = state_r;
      j_nxt_s     = j_r;
      stage_nxt_s = stage_r;
      mode_nxt_s  = mode_r;
      case (state_r)
         ST_IDLE: begin
            // a stalled pipeline does not accept a new transform
            if (start && !stall) begin
               state_nxt_s = ST_READ;
               j_nxt_s     = {(LOG_N-1){1'b0}};
               stage_nxt_s = {SW{1'b0}};
               mode_nxt_s  = mode;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_READ: begin
            if (stall) begin
               state_nxt_s = ST_READ;
            end else if (j_r == J_MAX) begin
               j_nxt_s = {(LOG_N-1){1'b0}};
               if (stage_r == S_MAX) begin
                  stage_nxt_s = {SW{1'b0}};
                  state_nxt_s = ST_DRAIN;
               end else begin
                  stage_nxt_s = stage_r + STAGE_ONE;
               end
            end else begin
               j_nxt_s = j_r + J_ONE;
            end
         end
         ST_DRAIN: begin
            // the cycle showing the final write is the done cycle
            if (wr_final_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            j_nxt_s     = {(LOG_N-1){1'b0}};
            stage_nxt_s = {SW{1'b0}};
         end
      endcase
   end

   // Read-beat datapath for the next beat; everything is zero when idle.
   always_comb begin
      rd_valid_nxt_s = (state_nxt_s == ST_READ);
      if (mode_nxt_s) begin
         pivot_nxt_s = stage_nxt_s;
      end else begin
         pivot_nxt_s = S_MAX - stage_nxt_s;
      end
      if (rd_valid_nxt_s) begin
         addr_a_nxt_s = lo_addr(j_nxt_s, pivot_nxt_s);
         addr_b_nxt_s = addr_a_nxt_s | (LOG_N'(1'b1) << pivot_nxt_s);
         tw_nxt_s     = tw_of(j_nxt_s, pivot_nxt_s);
      end else begin
         addr_a_nxt_s = {LOG_N{1'b0}};
         addr_b_nxt_s = {LOG_N{1'b0}};
         tw_nxt_s     = {(LOG_N-1){1'b0}};
      end
   end

   // Delay-line inputs: slot 0 takes the current read beat, others shift.
   always_comb begin
      final_beat_s = (state_r == ST_READ) && (j_r == J_MAX) && (stage_r == S_MAX);
      dl_in_s[0]   = {rd_valid_r, final_beat_s, rd_addr_a_r, rd_addr_b_r};
      for (int i = 1; i < WR_DELAY; i++) begin
         dl_in_s[i] = dl_r[i-1];
      end
      wr_final_s = dl_r[WR_DELAY-1][DW-1] & dl_r[WR_DELAY-1][DW-2];
   end

   // State, read outputs, delay line and status registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r      <= ST_IDLE;
         j_r          <= {(LOG_N-1){1'b0}};
         stage_r      <= {SW{1'b0}};
         mode_r       <= 1'b0;
         rd_addr_a_r  <= {LOG_N{1'b0}};
         rd_addr_b_r  <= {LOG_N{1'b0}};
         rd_valid_r   <= 1'b0;
         tw_idx_r     <= {(LOG_N-1){1'b0}};
         last_stage_r <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         for (int i = 0; i < WR_DELAY; i++) begin
            dl_r[i] <= {DW{1'b0}};
         end
      end else begin
         state_r      <= state_nxt_s;
         j_r          <= j_nxt_s;
         stage_r      <= stage_nxt_s;
         mode_r       <= mode_nxt_s;
         rd_addr_a_r  <= addr_a_nxt_s;
         rd_addr_b_r  <= addr_b_nxt_s;
         rd_valid_r   <= rd_valid_nxt_s;
         tw_idx_r     <= tw_nxt_s;
         last_stage_r <= rd_valid_nxt_s && (stage_nxt_s == S_MAX);
         busy_r       <= (state_nxt_s != ST_IDLE);
         if (!stall) begin
            for (int i = 0; i < WR_DELAY; i++) begin
               dl_r[i] <= dl_in_s[i];
            end
            // done rises together with the tail entry carrying the final beat
            done_r <= dl_in_s[WR_DELAY-1][DW-1] & dl_in_s[WR_DELAY-1][DW-2];
         end else begin
            done_r <= 1'b0;
         end
      end
   end

   assign rd_addr_a  = rd_addr_a_r;
   assign rd_addr_b  = rd_addr_b_r;
   assign rd_valid   = rd_valid_r;
   assign tw_idx     = tw_idx_r;
   assign stage      = stage_r;
   assign last_stage = last_stage_r;
   assign wr_valid   = dl_r[WR_DELAY-1][DW-1];
   assign wr_addr_a  = dl_r[WR_DELAY-1][2*LOG_N-1:LOG_N];
   assign wr_addr_b  = dl_r[WR_DELAY-1][LOG_N-1:0];
   assign busy       = busy_r;
   assign done       = done_r;

endmodule

// File: tb/tb_ntt_addr_gen.sv
// ----------------------------------------------------------------------------
// tb_ntt_addr_gen
// Directed self-checking bench. A small instance (LOG_N=3, WR_DELAY=2) is
// compared beat by beat against hand-computed address tables for forward,
// inverse, stalled and reset-aborted runs. A default instance (LOG_N=8,
// WR_DELAY=11) is checked for beat count, per-stage address coverage and
// completion time.
// ----------------------------------------------------------------------------
module tb_ntt_addr_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, mode, stall;
   logic b_start, b_mode, b_stall;

   logic [2:0] s_rd_a, s_rd_b, s_wr_a, s_wr_b;
   logic [1:0] s_tw, s_stage;
   logic       s_rd_valid, s_last, s_wr_valid, s_busy, s_done;

   logic [7:0] b_rd_a, b_rd_b, b_wr_a, b_wr_b;
   logic [6:0] b_tw;
   logic [2:0] b_stage;
   logic       b_rd_valid, b_last, b_wr_valid, b_busy, b_done;

   ntt_addr_gen #(.LOG_N(3), .WR_DELAY(2)) u_small (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .stall(stall),
      .rd_addr_a(s_rd_a), .rd_addr_b(s_rd_b), .rd_valid(s_rd_valid),
      .tw_idx(s_tw), .stage(s_stage), .last_stage(s_last),
      .wr_addr_a(s_wr_a), .wr_addr_b(s_wr_b), .wr_valid(s_wr_valid),
      .busy(s_busy), .done(s_done)
   );

   ntt_addr_gen u_big (
      .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .stall(b_stall),
      .rd_addr_a(b_rd_a), .rd_addr_b(b_rd_b), .rd_valid(b_rd_valid),
      .tw_idx(b_tw), .stage(b_stage), .last_stage(b_last),
      .wr_addr_a(b_wr_a), .wr_addr_b(b_wr_b), .wr_valid(b_wr_valid),
      .busy(b_busy), .done(b_done)
   );

   int n_checks = 0;
   int n_errs   = 0;

   // hand-computed (a, b, tw) per beat for N=8
   int fa[12] = '{0, 1, 2, 3,  0, 1, 4, 5,  0, 2, 4, 6};
   int fb[12] = '{4, 5, 6, 7,  2, 3, 6, 7,  1, 3, 5, 7};
   int ft[12] = '{0, 1, 2, 3,  0, 2, 0, 2,  0, 0, 0, 0};
   int ia[12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
   int ib[12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
   int it[12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

   int hits[8][256];

   // compare one observed value against its expected value
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One small-instance run. Expected outputs follow a tick counter that
   // advances on every non-stalled edge after the accepting edge.
   task automatic run_small(input logic md, input int stall_at, input int rst_at,
                            input int ncyc, input int exp_done, input string name);
      int  tick;
      int  done_at;
      bit  aborted;
      bit  moved;
      start = 1'b1;
      mode  = md;
      stall = 1'b0;
      step();
      start   = 1'b0;
      mode    = ~md;        // must already be latched
      tick    = 1;
      done_at = 0;
      aborted = 1'b0;
      moved   = 1'b1;
      for (int c = 1; c <= ncyc; c++) begin
         bit    v, wv;
         int    k, wk, ea, eb, et, wa, wb;
         string p;
         p  = $sformatf("%s c%0d", name, c);
         v  = !aborted && tick >= 1 && tick <= 12;
         wv = !aborted && tick >= 3 && tick <= 14;
         k  = tick - 1;
         wk = tick - 3;
         ea = 0; eb = 0; et = 0; wa = 0; wb = 0;
         if (v) begin
            ea = md ? ia[k] : fa[k];
            eb = md ? ib[k] : fb[k];
            et = md ? it[k] : ft[k];
         end
         if (wv) begin
            wa = md ? ia[wk] : fa[wk];
            wb = md ? ib[wk] : fb[wk];
         end
         check_eq({p, " rd_valid"}, 32'(s_rd_valid), 32'(v));
         check_eq({p, " rd_a"}, 32'(s_rd_a), 32'(ea));
         check_eq({p, " rd_b"}, 32'(s_rd_b), 32'(eb));
         check_eq({p, " tw"}, 32'(s_tw), 32'(et));
         check_eq({p, " stage"}, 32'(s_stage), 32'(v ? k / 4 : 0));
         check_eq({p, " last"}, 32'(s_last), 32'(v && k >= 8));
         check_eq({p, " wr_valid"}, 32'(s_wr_valid), 32'(wv));
         check_eq({p, " wr_a"}, 32'(s_wr_a), 32'(wa));
         check_eq({p, " wr_b"}, 32'(s_wr_b), 32'(wb));
         check_eq({p, " busy"}, 32'(s_busy), 32'(!aborted && tick >= 1 && tick <= 14));
         check_eq({p, " done"}, 32'(s_done), 32'(!aborted && tick == 14 && moved));
         if (s_done === 1'b1) done_at = c;
         if (c < ncyc) begin
            stall = (stall_at > 0) && (c >= stall_at) && (c < stall_at + 3);
            rst   = !((rst_at > 0) && (c == rst_at));
            // extra starts land mid-run and on the done cycle; both must be ignored
            start = (rst_at == 0) && (c == 5 || c == 14);
            step();
            if (!rst) aborted = 1'b1;
            moved = !stall;
            if (!stall && !aborted) tick++;
         end
      end
      start = 1'b0;
      stall = 1'b0;
      rst   = 1'b1;
      check_eq({name, " done_cycle"}, 32'(done_at), 32'(exp_done));
   endtask

   initial begin
      int cyc, beats, wbeats, lbeats, done_at, first_v, bad_pair, once;
      rst = 1'b0; start = 1'b0; mode = 1'b0; stall = 1'b0;
      b_start = 1'b0; b_mode = 1'b0; b_stall = 1'b0;
      step();
      step();
      check_eq("reset rd_valid", 32'(s_rd_valid), 32'd0);
      check_eq("reset rd_a", 32'(s_rd_a), 32'd0);
      check_eq("reset rd_b", 32'(s_rd_b), 32'd0);
      check_eq("reset tw", 32'(s_tw), 32'd0);
      check_eq("reset stage", 32'(s_stage), 32'd0);
      check_eq("reset last", 32'(s_last), 32'd0);
      check_eq("reset wr_valid", 32'(s_wr_valid), 32'd0);
      check_eq("reset wr_ab", 32'({s_wr_a, s_wr_b}), 32'd0);
      check_eq("reset busy", 32'(s_busy), 32'd0);
      check_eq("reset done", 32'(s_done), 32'd0);
      check_eq("reset big", 32'({b_busy, b_rd_valid, b_wr_valid, b_done}), 32'd0);
      rst = 1'b1;
      step();

      run_small(1'b0, 0, 0, 16, 14, "fwd");
      run_small(1'b1, 0, 0, 16, 14, "inv");
      run_small(1'b0, 6, 0, 20, 17, "stall");
      run_small(1'b0, 0, 7, 8, 0, "abort");
      run_small(1'b0, 0, 0, 16, 14, "after_abort");

      // default-parameter run
      for (int s = 0; s < 8; s++) begin
         for (int a = 0; a < 256; a++) hits[s][a] = 0;
      end
      beats = 0; wbeats = 0; lbeats = 0; done_at = -1; first_v = -1; bad_pair = 0;
      b_start = 1'b1;
      b_mode  = 1'b0;
      step();
      b_start = 1'b0;
      cyc = 1;
      while (cyc <= 1200 && done_at < 0) begin
         if (b_rd_valid === 1'b1) begin
            int st, ra, rb, pv;
            st = 32'(b_stage);
            ra = 32'(b_rd_a);
            rb = 32'(b_rd_b);
            pv = 7 - st;
            beats++;
            if (b_last === 1'b1) lbeats++;
            hits[st][ra]++;
            hits[st][rb]++;
            if (rb != (ra | (1 << pv)) || ((ra >> pv) & 1) != 0) bad_pair++;
            if (first_v < 0) first_v = cyc;
         end
         if (b_wr_valid === 1'b1) wbeats++;
         if (b_done === 1'b1) begin
            done_at = cyc;
         end else begin
            step();
            cyc++;
         end
      end
      check_eq("big first_rd", 32'(first_v), 32'd1);
      check_eq("big rd_beats", 32'(beats), 32'd1024);
      check_eq("big last_beats", 32'(lbeats), 32'd128);
      check_eq("big wr_beats", 32'(wbeats), 32'd1024);
      check_eq("big pair_err", 32'(bad_pair), 32'd0);
      check_eq("big done_cycle", 32'(done_at), 32'd1035);
      for (int s = 0; s < 8; s++) begin
         once = 0;
         for (int a = 0; a < 256; a++) begin
            if (hits[s][a] == 1) once++;
         end
         check_eq($sformatf("big cover s%0d", s), 32'(once), 32'd256);
      end
      step();
      check_eq("big idle busy", 32'(b_busy), 32'd0);
      check_eq("big idle done", 32'(b_done), 32'd0);
      check_eq("big idle rd", 32'({b_rd_valid, b_rd_a, b_rd_b}), 32'd0);
      check_eq("big idle tw_stage", 32'({b_tw, b_stage, b_last}), 32'd0);
      check_eq("big idle wr", 32'({b_wr_valid, b_wr_a, b_wr_b}), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
